// File: rtl/trace_event_pkg.sv
// rtl/trace_event_pkg.sv - opcode constants and decode helpers for the trace event monitor
package trace_event_pkg;

   localparam logic [7:0]  OP_NOP   = 8'h15;
   localparam logic [15:0] NOP_EXIT = 16'h0001;
   localparam logic [15:0] NOP_PUTC = 16'h0004;

   function automatic logic [15:0] nop_k(input logic [31:0] insn);
      return insn[15:0];
   endfunction

endpackage

// File: rtl/trace_char_fifo.sv
// rtl/trace_char_fifo.sv - per-core character FIFO; a push while full is accepted when a pop frees a slot
module trace_char_fifo #(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       pop,
   output logic [7:0] pop_data,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_pop;
   logic          do_push;

   assign empty    = (count == '0);
   assign full     = (count == (AW+1)'(DEPTH));
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

   // Storage needs no reset: contents are only observed behind a non-zero count.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/trace_event_monitor.sv
// rtl/trace_event_monitor.sv - decodes l.nop simulation controls from core traces into exits, putc stream and watchdog
module trace_event_monitor
   import trace_event_pkg::*;
#(
   parameter int NUM_CORES      = 4,
   parameter int REG_IDX        = 3,
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 0,
   parameter int TIMEOUT_W      = 32,
   localparam int CW            = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
   input  logic                   clk,
   input  logic                   rst_sys_n,
   input  logic [NUM_CORES-1:0]    trace_enable,
   input  logic [32*NUM_CORES-1:0] trace_insn,
   input  logic [NUM_CORES-1:0]    trace_wben,
   input  logic [5*NUM_CORES-1:0]  trace_wbreg,
   input  logic [32*NUM_CORES-1:0] trace_wbdata,
   output logic                   char_valid,
   output logic [7:0]             char_data,
   output logic [CW-1:0]          char_core,
   input  logic                   char_ready,
   output logic [NUM_CORES-1:0]    terminated,
   output logic [32*NUM_CORES-1:0] exit_code,
   output logic                   all_terminated,
   output logic [NUM_CORES-1:0]    overflow,
   output logic                   timeout
);

   logic [31:0]          shadow [NUM_CORES];
   logic [7:0]           fifo_data [NUM_CORES];
   logic [NUM_CORES-1:0] shadow_wr;
   logic [NUM_CORES-1:0] exit_hit;
   logic [NUM_CORES-1:0] push;
   logic [NUM_CORES-1:0] pop;
   logic [NUM_CORES-1:0] full;
   logic [NUM_CORES-1:0] empty;
   logic [NUM_CORES-1:0] insn_unused;
   logic [CW-1:0]        last;
   logic [CW-1:0]        pick;
   logic [CW-1:0]        sel;
   logic                 found;
   logic                 load;

   for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
      logic [31:0] insn;
      logic        nop_hit;

      assign insn           = trace_insn[32*i +: 32];
      assign nop_hit        = trace_enable[i] && (insn[31:24] == OP_NOP) && !terminated[i];
      assign exit_hit[i]    = nop_hit && (nop_k(insn) == NOP_EXIT);
      assign push[i]        = nop_hit && (nop_k(insn) == NOP_PUTC);
      assign shadow_wr[i]   = trace_enable[i] && trace_wben[i] && (trace_wbreg[5*i +: 5] == 5'(REG_IDX));
      assign insn_unused[i] = ^insn[23:16];
      assign pop[i]         = load && (pick == CW'(i));

      trace_char_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
         .clk       (clk),
         .rst_n     (rst_sys_n),
         .push      (push[i]),
         .push_data (shadow[i][7:0]),
         .pop       (pop[i]),
         .pop_data  (fifo_data[i]),
         .full      (full[i]),
         .empty     (empty[i])
      );
   end

   // A nop never writes back, so decode reading the pre-update shadow is exact.
   always_ff @(posedge clk or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         for (int i = 0; i < NUM_CORES; i++) shadow[i] <= '0;
         terminated <= '0;
         exit_code  <= '0;
         overflow   <= '0;
      end else begin
         for (int i = 0; i < NUM_CORES; i++) begin
            if (shadow_wr[i]) shadow[i] <= trace_wbdata[32*i +: 32];
            if (exit_hit[i]) begin
               terminated[i]         <= 1'b1;
               exit_code[32*i +: 32] <= shadow[i];
            end
            if (push[i] && full[i] && !pop[i]) overflow[i] <= 1'b1;
         end
      end
   end

   // Round-robin search starts one past the core served last.
   always_comb begin
      found = 1'b0;
      pick  = last;
      sel   = last;
      for (int off = 1; off <= NUM_CORES; off++) begin
         sel = CW'((int'(last) + off) % NUM_CORES);
         if (!found && !empty[sel]) begin
            found = 1'b1;
            pick  = sel;
         end
      end
   end

   assign load = found && (!char_valid || char_ready);

   always_ff @(posedge clk or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         char_valid     <= 1'b0;
         char_data      <= '0;
         char_core      <= '0;
         last           <= CW'(NUM_CORES - 1);
         all_terminated <= 1'b0;
      end else begin
         if (load) begin
            char_valid <= 1'b1;
            char_data  <= fifo_data[pick];
            char_core  <= pick;
            last       <= pick;
         end else if (char_ready) begin
            char_valid <= 1'b0;
         end
         all_terminated <= (&terminated) && (&empty) && !char_valid;
      end
   end

   if (TIMEOUT_CYCLES > 0) begin : g_watchdog
      logic [TIMEOUT_W-1:0] wd_count;

      always_ff @(posedge clk or negedge rst_sys_n) begin
         if (!rst_sys_n) begin
            wd_count <= '0;
            timeout  <= 1'b0;
         end else if (!all_terminated) begin
            if (|trace_enable) begin
               wd_count <= '0;
            end else begin
               if (wd_count != '1) wd_count <= wd_count + 1'b1;
               if (wd_count >= TIMEOUT_W'(TIMEOUT_CYCLES - 1)) timeout <= 1'b1;
            end
         end
      end
   end else begin : g_no_watchdog
      assign timeout = 1'b0;
   end

endmodule

// File: tb/tb_trace_event_monitor.sv
// tb/tb_trace_event_monitor.sv - scoreboard bench for trace_event_monitor with directed vectors
module tb_trace_event_monitor;

   localparam int NC = 4;
   localparam int CW = 2;

   logic              clk = 1'b0;
   logic              rst_sys_n = 1'b0;
   logic [NC-1:0]     trace_enable;
   logic [32*NC-1:0]  trace_insn;
   logic [NC-1:0]     trace_wben;
   logic [5*NC-1:0]   trace_wbreg;
   logic [32*NC-1:0]  trace_wbdata;
   logic              char_valid;
   logic [7:0]        char_data;
   logic [CW-1:0]     char_core;
   logic              char_ready;
   logic [NC-1:0]     terminated;
   logic [32*NC-1:0]  exit_code;
   logic              all_terminated;
   logic [NC-1:0]     overflow;
   logic              timeout;

   int n_vec = 0;
   int n_err = 0;
   logic [9:0] exp_q[$];

   always #5 clk = ~clk;

   trace_event_monitor #(
      .NUM_CORES(NC), .REG_IDX(3), .FIFO_DEPTH(8), .TIMEOUT_CYCLES(100), .TIMEOUT_W(32)
   ) dut (
      .clk(clk), .rst_sys_n(rst_sys_n),
      .trace_enable(trace_enable), .trace_insn(trace_insn), .trace_wben(trace_wben),
      .trace_wbreg(trace_wbreg), .trace_wbdata(trace_wbdata),
      .char_valid(char_valid), .char_data(char_data), .char_core(char_core), .char_ready(char_ready),
      .terminated(terminated), .exit_code(exit_code), .all_terminated(all_terminated),
      .overflow(overflow), .timeout(timeout)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic run_monitor();
      logic [9:0] e;
      forever begin
         @(negedge clk);
         if (rst_sys_n && char_valid && char_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL char_unexpected: got core %0d data %0h, expected none", char_core, char_data);
            end else begin
               e = exp_q.pop_front();
               check("char_out", 32'({char_core, char_data}), 32'(e));
            end
         end
      end
   endtask

   task automatic clear_in();
      trace_enable = '0;
      trace_insn   = '0;
      trace_wben   = '0;
      trace_wbreg  = '0;
      trace_wbdata = '0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      clear_in();
   endtask

   task automatic set_wr(input int c, input logic [31:0] d);
      trace_enable[c]          = 1'b1;
      trace_insn[32*c +: 32]   = 32'hE0630000;
      trace_wben[c]            = 1'b1;
      trace_wbreg[5*c +: 5]    = 5'd3;
      trace_wbdata[32*c +: 32] = d;
   endtask

   task automatic set_nop(input int c, input logic [15:0] k);
      trace_enable[c]        = 1'b1;
      trace_insn[32*c +: 32] = {8'h15, 8'h00, k};
   endtask

   task automatic wr(input int c, input logic [31:0] d);
      set_wr(c, d);
      cyc();
   endtask

   task automatic nop(input int c, input logic [15:0] k);
      set_nop(c, k);
      cyc();
   endtask

   task automatic do_reset();
      rst_sys_n = 1'b0;
      exp_q.delete();
      char_ready = 1'b1;
      clear_in();
      repeat (2) @(posedge clk);
      #1;
      rst_sys_n = 1'b1;
   endtask

   initial begin
      logic [5:0] pat;
      clear_in();
      char_ready = 1'b1;
      fork
         run_monitor();
      join_none

      do_reset();
      check("rst_char_valid", 32'(char_valid), 32'd0);
      check("rst_char_data", 32'(char_data), 32'd0);
      check("rst_char_core", 32'(char_core), 32'd0);
      check("rst_terminated", 32'(terminated), 32'd0);
      check("rst_exit_code_nz", 32'(|exit_code), 32'd0);
      check("rst_all_term", 32'(all_terminated), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);

      // single putc latency
      wr(0, 32'h41);
      exp_q.push_back({2'd0, 8'h41});
      nop(0, 16'h0004);
      @(negedge clk);
      check("lat_cycle1_valid", 32'(char_valid), 32'd0);
      @(negedge clk);
      check("lat_cycle2_valid", 32'(char_valid), 32'd1);
      repeat (3) cyc();

      // four cores in the same cycle
      do_reset();
      for (int c = 0; c < NC; c++) set_wr(c, 32'h61 + c);
      cyc();
      for (int c = 0; c < NC; c++) begin
         set_nop(c, 16'h0004);
         exp_q.push_back({2'(c), 8'(8'h61 + c)});
      end
      cyc();
      pat = '0;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         pat = {pat[4:0], char_valid};
      end
      check("rr_valid_pattern", 32'(pat), 32'h1E);

      // overflow on core 1
      do_reset();
      char_ready = 1'b0;
      for (int n = 0; n < 10; n++) begin
         wr(1, 32'h30 + n);
         nop(1, 16'h0004);
         if (n < 9) exp_q.push_back({2'd1, 8'(8'h30 + n)});
      end
      check("ovf_flags", 32'(overflow), 32'h2);
      check("ovf_held_data", 32'(char_data), 32'h30);
      char_ready = 1'b1;
      repeat (15) cyc();
      check("ovf_drained", exp_q.size(), 32'd0);
      check("ovf_sticky", 32'(overflow), 32'h2);

      // repeated exit keeps first code, putc after exit ignored
      do_reset();
      wr(2, 32'd7);
      nop(2, 16'h0001);
      wr(2, 32'd9);
      nop(2, 16'h0001);
      @(negedge clk);
      check("exit_terminated", 32'(terminated), 32'h4);
      check("exit_code2", exit_code[95:64], 32'd7);
      check("exit_code_others", 32'(|{exit_code[127:96], exit_code[63:0]}), 32'd0);
      wr(2, 32'h5A);
      nop(2, 16'h0004);
      repeat (4) cyc();
      check("exit_no_putc", 32'(char_valid), 32'd0);
      check("exit_partial_all_term", 32'(all_terminated), 32'd0);

      // all exit while core 3 still has buffered characters
      do_reset();
      char_ready = 1'b0;
      for (int n = 0; n < 3; n++) begin
         wr(3, 32'h78 + n);
         nop(3, 16'h0004);
         exp_q.push_back({2'd3, 8'(8'h78 + n)});
      end
      for (int c = 0; c < NC; c++) set_nop(c, 16'h0001);
      cyc();
      repeat (3) cyc();
      check("drain_terminated", 32'(terminated), 32'hF);
      check("drain_exit_code3", exit_code[127:96], 32'h7A);
      check("drain_all_term_hold", 32'(all_terminated), 32'd0);
      for (int h = 0; h < 3; h++) begin
         char_ready = 1'b1;
         @(posedge clk);
         #1;
         char_ready = 1'b0;
         @(negedge clk);
         check($sformatf("drain_all_term_after_hs%0d", h), 32'(all_terminated), 32'd0);
      end
      @(negedge clk);
      check("drain_all_term_set", 32'(all_terminated), 32'd1);

      // reset while a character is waiting
      do_reset();
      char_ready = 1'b0;
      wr(0, 32'h71);
      nop(0, 16'h0004);
      repeat (2) cyc();
      check("midrst_valid_before", 32'(char_valid), 32'd1);
      exp_q.delete();
      rst_sys_n = 1'b0;
      #1;
      check("midrst_valid", 32'(char_valid), 32'd0);
      check("midrst_data", 32'(char_data), 32'd0);
      @(posedge clk);
      #1;
      rst_sys_n = 1'b1;
      char_ready = 1'b1;
      repeat (5) cyc();
      check("midrst_no_output", 32'(char_valid), 32'd0);

      // watchdog, no retire at all
      do_reset();
      repeat (99) @(posedge clk);
      #1;
      check("wd_idle_99", 32'(timeout), 32'd0);
      @(posedge clk);
      #1;
      check("wd_idle_100", 32'(timeout), 32'd1);

      // watchdog, one retire at cycle 50
      do_reset();
      repeat (49) @(posedge clk);
      #1;
      trace_enable[1] = 1'b1;
      trace_insn[63:32] = 32'hE0000000;
      cyc();
      repeat (99) @(posedge clk);
      #1;
      check("wd_retire_149", 32'(timeout), 32'd0);
      @(posedge clk);
      #1;
      check("wd_retire_150", 32'(timeout), 32'd1);

      check("final_queue_empty", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
